// File: rtl/inv_subcell_serial_if.sv
// rtl/inv_subcell_serial_if.sv - state-in / state-out handshake bundle for the inverse SubCell layer
interface inv_subcell_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_subcell_serial.sv
// rtl/inv_subcell_serial.sv - lane-serial inverse 4-bit S-box over a 128-bit state
module inv_subcell_serial #(
    parameter int LANES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_subcell_serial_if.slave  bus,
    output logic                 busy
);
    localparam int N  = 32 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [127:0]    work;
    logic [CW-1:0]   cnt;
    logic [4*LANES-1:0] sub;
    logic [127:0]    rot;

    function automatic logic [3:0] invs(input logic [3:0] x);
        case (x)
            4'h0: invs = 4'hB;
            4'h1: invs = 4'h0;
            4'h2: invs = 4'h7;
            4'h3: invs = 4'hD;
            4'h4: invs = 4'hC;
            4'h5: invs = 4'hF;
            4'h6: invs = 4'h2;
            4'h7: invs = 4'h4;
            4'h8: invs = 4'h6;
            4'h9: invs = 4'h1;
            4'hA: invs = 4'h8;
            4'hB: invs = 4'hE;
            4'hC: invs = 4'h5;
            4'hD: invs = 4'hA;
            4'hE: invs = 4'h9;
            default: invs = 4'h3;
        endcase
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sub[4*i +: 4] = invs(work[4*i +: 4]);
    end

    // Substituted lanes re-enter at the top so after N steps every nibble is home.
    if (LANES == 32) begin : g_full
        assign rot = sub;
    end else begin : g_rot
        assign rot = {sub, work[127:4*LANES]};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid) state_n = BUSY;
            BUSY:    if (cnt == LAST) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= 128'h0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work <= bus.in_data;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    work <= rot;
                    cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = work;
    assign busy          = (state == BUSY) || (state == DONE);
endmodule

// File: tb/tb_inv_subcell_serial.sv
// tb/tb_inv_subcell_serial.sv - directed checks of inv_subcell_serial at LANES=8 plus a width sweep
module tb_inv_subcell_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] MIX_IN  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] MIX_OUT = 128'hB07DCF24618E5A93B07DCF24618E5A93;
    localparam logic [127:0] ZERO_OUT = 128'hBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBB;
    localparam logic [127:0] FIVES   = 128'h55555555555555555555555555555555;
    localparam logic [127:0] EFFS    = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;

    inv_subcell_serial_if bus();
    logic busy;

    inv_subcell_serial #(.LANES(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    logic         w_valid = 1'b0;
    logic [127:0] w_data  = 128'h0;
    logic         w_ready = 1'b0;
    logic [5:0]   w_ov;
    logic [5:0]   w_ir;
    logic [5:0]   w_busy;
    logic [127:0] w_od [6];

    for (genvar g = 0; g < 6; g++) begin : g_w
        inv_subcell_serial_if wif();
        assign wif.in_valid  = w_valid;
        assign wif.in_data   = w_data;
        assign wif.out_ready = w_ready;
        inv_subcell_serial #(.LANES(1 << g)) u (
            .clk  (clk),
            .rst  (rst),
            .bus  (wif.slave),
            .busy (w_busy[g])
        );
        assign w_ov[g] = wif.out_valid;
        assign w_ir[g] = wif.in_ready;
        assign w_od[g] = wif.out_data;
    end

    function automatic logic [127:0] fwd(input logic [127:0] x);
        logic [3:0] t [16] = '{4'h1, 4'h9, 4'h6, 4'hF, 4'h7, 4'hC, 4'h8, 4'h2,
                               4'hA, 4'hE, 4'hD, 4'h0, 4'h4, 4'h3, 4'hB, 4'h5};
        logic [127:0] r;
        for (int i = 0; i < 32; i++) r[4*i +: 4] = t[x[4*i +: 4]];
        return r;
    endfunction

    // Drives one block on the main DUT and returns its latency (-1 on timeout) and result.
    task automatic run_block(input logic [127:0] d, output logic [127:0] q, output int lat);
        lat = -1;
        q   = 128'h0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat = k;
                q   = bus.out_data;
                break;
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        int lat;
        logic [127:0] q;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_state: ir=%b ov=%b busy=%b od=%h, want 1 0 0 0", bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h0;
        lat = -1;
        q   = 128'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (k <= 5) begin
                total++;
                if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL zero_busy k=%0d: ir=%b busy=%b, want 0 1", k, bus.in_ready, busy);
                end
            end
            if (bus.out_valid) begin
                lat = k;
                q   = bus.out_data;
                break;
            end
        end
        total++;
        if (lat !== 5) begin bad++; $display("FAIL zero_latency: got %0d want 5", lat); end
        total++;
        if (q !== ZERO_OUT) begin bad++; $display("FAIL zero_data: got %h want %h", q, ZERO_OUT); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_widths;
        int lat [6];
        logic [127:0] dat [6];
        for (int g = 0; g < 6; g++) begin lat[g] = -1; dat[g] = 128'h0; end
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = MIX_IN;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            w_valid = 1'b0;
            w_data  = 128'hDEADBEEF;
            for (int g = 0; g < 6; g++) begin
                if (w_ov[g] && lat[g] < 0) begin
                    lat[g] = k;
                    dat[g] = w_od[g];
                end
            end
        end
        for (int g = 0; g < 6; g++) begin
            total++;
            if (lat[g] !== (32 >> g) + 1) begin
                bad++;
                $display("FAIL width_latency lanes=%0d: got %0d want %0d", 1 << g, lat[g], (32 >> g) + 1);
            end
            total++;
            if (dat[g] !== MIX_OUT) begin
                bad++;
                $display("FAIL width_data lanes=%0d: got %h want %h", 1 << g, dat[g], MIX_OUT);
            end
        end
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        @(negedge clk);
        total++;
        if (w_ir !== 6'h3F || w_ov !== 6'h00 || w_busy !== 6'h00) begin
            bad++;
            $display("FAIL width_idle: ir=%b ov=%b busy=%b want 111111 000000 000000", w_ir, w_ov, w_busy);
        end
    endtask

    task automatic test_round_trip;
        logic [127:0] x, q;
        int lat, errs;
        run_block(FIVES, q, lat);
        total++;
        if (q !== EFFS || lat !== 5) begin
            bad++;
            $display("FAIL rt_fives: got %h lat=%0d want %h lat=5", q, lat, EFFS);
        end
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run_block(fwd(x), q, lat);
            total++;
            if (q !== x || lat !== 5) begin
                bad++;
                errs++;
                if (errs <= 5) $display("FAIL rt_random %0d: got %h lat=%0d want %h lat=5", n, q, lat, x);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] q;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = MIX_IN;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin lat = k; break; end
        end
        total++;
        if (lat !== 5) begin bad++; $display("FAIL bp_latency: got %0d want 5", lat); end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = FIVES;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== MIX_OUT || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold %0d: ov=%b od=%h ir=%b want 1 %h 0", k, bus.out_valid, bus.out_data, bus.in_ready, MIX_OUT);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        lat = -1;
        q   = 128'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin lat = k; q = bus.out_data; break; end
        end
        total++;
        if (q !== EFFS || lat !== 5) begin
            bad++;
            $display("FAIL bp_second: got %h lat=%0d want %h lat=5", q, lat, EFFS);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [127:0] q;
        int lat, pulses;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = MIX_IN;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 128'h0) begin
            bad++;
            $display("FAIL mid_reset_state: ir=%b ov=%b busy=%b od=%h want 1 0 0 0", bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL mid_reset_no_output: got %0d pulses want 0", pulses); end
        run_block(MIX_IN, q, lat);
        total++;
        if (q !== MIX_OUT || lat !== 5) begin
            bad++;
            $display("FAIL mid_reset_next: got %h lat=%0d want %h lat=5", q, lat, MIX_OUT);
        end
        // Reset in DONE with out_ready high at the same edge must still win.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = FIVES;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL done_before_reset: ov=%b want 1", bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 128'h0) begin
            bad++;
            $display("FAIL done_reset_state: ir=%b ov=%b busy=%b od=%h want 1 0 0 0", bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] blk [3] = '{MIX_IN, 128'h0, FIVES};
        logic [127:0] exp_out [3] = '{MIX_OUT, ZERO_OUT, EFFS};
        logic [127:0] got [3];
        int when [3];
        int idx, nout;
        idx  = 0;
        nout = 0;
        for (int i = 0; i < 3; i++) begin got[i] = 128'h0; when[i] = -1; end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (nout < 3) begin got[nout] = bus.out_data; when[nout] = k; end
                nout++;
            end
            if (bus.in_ready) begin
                if (idx < 3) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = blk[idx];
                    idx++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (nout !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", nout); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== exp_out[i]) begin
                bad++;
                $display("FAIL b2b_data %0d: got %h want %h", i, got[i], exp_out[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (when[i] - when[i-1] !== 6) begin
                bad++;
                $display("FAIL b2b_spacing %0d: got %0d want 6", i, when[i] - when[i-1]);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 128'h0;
        bus.out_ready = 1'b0;
        test_reset;
        test_widths;
        test_round_trip;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inv_subcell_serial.md
# inv_subcell_serial

Lane-serial inverse SubCell layer for the 128-bit block-cipher decryption datapath. It accepts one 128-bit state over a valid/ready handshake and applies the inverse 4-bit S-box to all 32 nibbles, `LANES` nibbles per clock. It then presents the result on a valid/ready output that honours backpressure. It sits between the inverse linear layer and the round-key XOR in the decryption round.

## Interface
- `LANES`, default 8: nibbles processed per cycle. Legal values are 1, 2, 4, 8, 16, 32. Steps per block: `N = 32/LANES`.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `in_valid` input 1: `in_data` carries a state.
- `in_ready` output 1: the block can accept a state.
- `in_data` input 128: ciphertext-side state. Nibble i is `in_data[4i+3:4i]`.
- `out_valid` output 1: `out_data` holds a finished result.
- `out_ready` input 1: the downstream stage accepts the result.
- `out_data` output 128: inverse-substituted state, driven directly from the work register.
- `busy` output 1: high while in BUSY or DONE.

## Operation
- The inverse S-box maps input nibble values 0..F to: B,0,7,D,C,F,2,4,6,1,8,E,5,A,9,3.
  - The forward S-box, used for cross-checking only, maps 0..F to: 1,9,6,F,7,C,8,2,A,E,D,0,4,3,B,5.
- Bit order within a nibble: bit0 = LSB, unchanged from the forward layer.
- State machine:
  - IDLE → BUSY on the input handshake (`in_valid & in_ready`).
  - BUSY → DONE when the step counter reaches `N-1`.
  - DONE → IDLE on the output handshake (`out_valid & out_ready`).
- IDLE:
  - `in_ready = 1`.
  - On handshake: `work <= in_data`, `cnt <= 0`.
- BUSY, each cycle:
  - `work <= {invS(work[4·LANES-1:0]) per nibble, work[127:4·LANES]}`. That is, substitute the low `LANES` nibbles and rotate right by `4·LANES` bits.
  - `cnt <= cnt + 1`.
  - After N steps every nibble has been substituted exactly once and is back in its original position.
- DONE:
  - `out_valid = 1`.
  - `work` is frozen until the output handshake.
- `cnt` width is `max(1, clog2(N))`. It is never compared against a value ≥ N. With `LANES=32` (N=1), BUSY lasts exactly one cycle.
- `in_valid` outside IDLE is ignored: `in_ready = 0`, no capture, no error.
- `out_ready` outside DONE is ignored.
- `in_data` is sampled only on the handshake edge. Later changes to it have no effect.

## Timing
- Reset values: state = IDLE, `work = 0`, `cnt = 0`. Hence `in_ready = 1`, `out_valid = 0`, `busy = 0`, `out_data = 128'h0`.
  - A `rst` pulse in any state, including mid-BUSY or in DONE with `out_valid` high, returns to these values on the next edge.
  - The partially processed block is discarded and never presented.
  - `rst` has priority over both handshakes in the same cycle.
- Input handshake in cycle t:
  - BUSY during cycles t+1 .. t+N.
  - `out_valid = 1` from cycle t+N+1.
  - Latency is N+1 cycles; for the default `LANES=8`, N=4 and `out_valid` rises in cycle t+5.
- `out_valid` and `out_data` are held stable until `out_ready` is sampled high.
- Output handshake in cycle u: IDLE and `in_ready = 1` in cycle u+1.
  - No same-cycle accept while in DONE.
  - Maximum throughput is one block per N+2 cycles with `out_ready` tied high.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from any input to any output.
- `out_data` during IDLE/BUSY is the raw work register and is don't-care to consumers. The bench checks it only when `out_valid = 1`.

## Test plan
- **Reset, zero state.** After `rst`, `in_data = 0` with `in_valid` pulsed for 1 cycle (LANES=8):
  - `out_valid` rises exactly 5 cycles after the handshake.
  - `out_data = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB`.
  - `in_ready = 0` during those 5 cycles.
- **Mixed state, every legal width.** `in_data = 128'h0123456789ABCDEF0123456789ABCDEF` → `out_data = 128'hB07DCF24618E5A93B07DCF24618E5A93`.
  - Repeat for every legal `LANES`; latency = 32/LANES + 1.
- **Round trip.** 1000 random states X; drive `fwdS(X)` (per-nibble forward table) → `out_data == X` for each.
  - Include `X = 128'hFFFF…F` → input `128'h5555…5`.
- **Backpressure.** Hold `out_ready = 0` for 10 cycles after `out_valid` rises:
  - `out_valid` and `out_data` stay stable.
  - `in_ready` stays 0 even with `in_valid = 1` and a new `in_data`.
  - Release: one output handshake, then `in_ready = 1` in the next cycle.
  - The second block's result is then correct.
- **Reset mid-operation.** Assert `rst` 2 cycles after the input handshake:
  - Next cycle: `in_ready = 1`, `out_valid = 0`, `busy = 0`, `out_data = 0`.
  - No `out_valid` pulse follows.
  - A subsequent block produces the correct result with nominal latency.
- **Back-to-back.** `in_valid` and `out_ready` tied high, 3 distinct blocks:
  - 3 outputs in order, spaced N+2 cycles apart.
  - No block dropped or duplicated.
